// File: rtl/alu_issue_scheduler_pkg.sv
// Shared ROB/PRF tag types, RS payload layout and ROB-order helpers.
package alu_issue_scheduler_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_W     = 5;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned DIST_W    = ROB_W + 1;

  typedef logic [ROB_W-1:0]  rob_tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t      pd;
    preg_t      ps1;
    preg_t      ps2;
    rob_tag_t   rob_index;
    logic [6:0] opcode;
    logic [2:0] func;
    logic [11:0] imm;
  } rs_data_t;

  // (a - b) mod ROB_DEPTH without treating any tag bit as an ordering bit.
  function automatic rob_tag_t rob_dist(input rob_tag_t a, input rob_tag_t b);
    logic [DIST_W-1:0] d;
    d = {1'b0, a} + DIST_W'(ROB_DEPTH) - {1'b0, b};
    if (d >= DIST_W'(ROB_DEPTH)) d = d - DIST_W'(ROB_DEPTH);
    return d[ROB_W-1:0];
  endfunction

  // True for ops younger than the branch mtag but older than the next allocation.
  function automatic logic rob_in_flush(input rob_tag_t tag, input rob_tag_t mtag,
                                        input rob_tag_t curr);
    rob_tag_t d;
    rob_tag_t l;
    d = rob_dist(tag, mtag);
    l = rob_dist(curr, mtag);
    return (d != '0) && (d < l);
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_rs_age_select.sv
// Oldest-ready picker: smallest age wins, ties resolved to the lowest index.
module alu_issue_scheduler_rs_age_select
  import alu_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    [DEPTH-1:0] ready,
  input  rob_tag_t [DEPTH-1:0]                age,
  output logic                    [DEPTH-1:0] grant,
  output logic                                any_ready
);

  rob_tag_t best_age;

  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    best_age  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ready[i] && (!any_ready || (age[i] < best_age))) begin
        grant     = '0;
        grant[i]  = 1'b1;
        any_ready = 1'b1;
        best_age  = age[i];
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: dispatch, CDB wakeup, oldest-ready issue and branch squash.
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N_CDB = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  rs_data_t                  disp_data,
  input  logic                      disp_ps1_rdy,
  input  logic                      disp_ps2_rdy,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*PREG_W-1:0]   cdb_tag,
  input  rob_tag_t                  rob_head,
  input  rob_tag_t                  curr_rob_tag,
  input  logic                      mispredict,
  input  rob_tag_t                  mispredict_tag,
  input  logic                      fu_ready,
  output logic                      issued,
  output rs_data_t                  issue_data,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     valid_q, r1_q, r2_q;
  rs_data_t [DEPTH-1:0] data_q;

  logic [DEPTH-1:0]     rdy1_c, rdy2_c, ready_c, grant_c, free_c, valid_nxt_c;
  rob_tag_t [DEPTH-1:0] age_c;
  logic                 any_ready_c, do_issue_c, do_disp_c, disp_r1_c, disp_r2_c;
  rs_data_t             issue_sel_c;
  logic [OCC_W-1:0]     occ_nxt_c;

  function automatic logic cdb_hit(input preg_t tag, input logic [N_CDB-1:0] v,
                                   input logic [N_CDB*PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(N_CDB); k++)
      if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = (occupancy < OCC_W'(DEPTH)) && !mispredict;
  assign do_disp_c  = disp_valid && disp_ready;
  assign do_issue_c = fu_ready && !mispredict && any_ready_c;
  assign disp_r1_c  = disp_ps1_rdy || cdb_hit(disp_data.ps1, cdb_valid, cdb_tag) ||
                      (disp_data.ps1 == '0);
  assign disp_r2_c  = disp_ps2_rdy || cdb_hit(disp_data.ps2, cdb_valid, cdb_tag) ||
                      (disp_data.ps2 == '0);

  // Operand readiness including same-cycle CDB bypass, plus ROB-relative age.
  always_comb begin
    rdy1_c  = '0;
    rdy2_c  = '0;
    ready_c = '0;
    age_c   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rdy1_c[i]  = r1_q[i] || cdb_hit(data_q[i].ps1, cdb_valid, cdb_tag) || (data_q[i].ps1 == '0);
      rdy2_c[i]  = r2_q[i] || cdb_hit(data_q[i].ps2, cdb_valid, cdb_tag) || (data_q[i].ps2 == '0);
      ready_c[i] = valid_q[i] && rdy1_c[i] && rdy2_c[i];
      age_c[i]   = rob_dist(data_q[i].rob_index, rob_head);
    end
  end

  alu_issue_scheduler_rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .ready     (ready_c),
    .age       (age_c),
    .grant     (grant_c),
    .any_ready (any_ready_c)
  );

  // Free-slot pick, issue mux and next valid vector (squash applied last).
  always_comb begin
    free_c      = '0;
    issue_sel_c = '0;
    occ_nxt_c   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_c    = '0;
        free_c[i] = 1'b1;
      end
      if (grant_c[i]) issue_sel_c = data_q[i];
    end
    valid_nxt_c = (valid_q & ~(grant_c & {DEPTH{do_issue_c}})) | (free_c & {DEPTH{do_disp_c}});
    if (mispredict) begin
      for (int i = 0; i < int'(DEPTH); i++)
        if (rob_in_flush(data_q[i].rob_index, mispredict_tag, curr_rob_tag))
          valid_nxt_c[i] = 1'b0;
    end
    for (int i = 0; i < int'(DEPTH); i++) occ_nxt_c = occ_nxt_c + OCC_W'(valid_nxt_c[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      occupancy  <= '0;
      issued     <= 1'b0;
      issue_data <= '0;
    end else begin
      valid_q   <= valid_nxt_c;
      occupancy <= occ_nxt_c;
      issued    <= do_issue_c;
      if (do_issue_c) issue_data <= issue_sel_c;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (do_disp_c && free_c[i]) begin
          data_q[i] <= disp_data;
          r1_q[i]   <= disp_r1_c;
          r2_q[i]   <= disp_r2_c;
        end else begin
          r1_q[i]   <= rdy1_c[i];
          r2_q[i]   <= rdy2_c[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for the ALU issue scheduler: latency, wakeup, age/wrap, full, squash, stall.
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned N_CDB = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    disp_valid;
  logic                    disp_ready;
  rs_data_t                disp_data;
  logic                    disp_ps1_rdy, disp_ps2_rdy;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*PREG_W-1:0] cdb_tag;
  rob_tag_t                rob_head, curr_rob_tag, mispredict_tag;
  logic                    mispredict;
  logic                    fu_ready;
  logic                    issued;
  rs_data_t                issue_data;
  logic [$clog2(DEPTH):0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
    .clk            (clk),
    .reset          (reset),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_data      (disp_data),
    .disp_ps1_rdy   (disp_ps1_rdy),
    .disp_ps2_rdy   (disp_ps2_rdy),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .rob_head       (rob_head),
    .curr_rob_tag   (curr_rob_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .fu_ready       (fu_ready),
    .issued         (issued),
    .issue_data     (issue_data),
    .occupancy      (occupancy)
  );

  function automatic rs_data_t mk(input int unsigned rob, input int unsigned ps1,
                                  input int unsigned ps2);
    rs_data_t d;
    d.pd        = PREG_W'(rob + 40);
    d.ps1       = PREG_W'(ps1);
    d.ps2       = PREG_W'(ps2);
    d.rob_index = ROB_W'(rob);
    d.opcode    = 7'h33;
    d.func      = 3'(rob);
    d.imm       = 12'(rob * 3);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_valid = 1'b0; disp_data = '0; disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
    cdb_valid = '0; cdb_tag = '0; rob_head = '0; curr_rob_tag = '0; mispredict = 1'b0;
    mispredict_tag = '0; fu_ready = 1'b1;
    step(); step();
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL reset_issued got %0b exp 0", issued); end
    checks++; if (issue_data !== '0) begin errors++; $display("FAIL reset_issue_data got %h exp 0", issue_data); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %0b exp 1", disp_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic_latency();
    disp_data = mk(3, 5, 0); disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1; disp_valid = 1'b1;
    step();
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ_written got %0d exp 1", occupancy); end
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL basic_no_early_issue got %0b exp 0", issued); end
    disp_valid = 1'b0;
    step();
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL basic_issued got %0b exp 1", issued); end
    checks++; if (issue_data !== mk(3, 5, 0)) begin errors++; $display("FAIL basic_payload got %h exp %h", issue_data, mk(3, 5, 0)); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ_drained got %0d exp 0", occupancy); end
    step();
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL basic_strobe_drop got %0b exp 0", issued); end
    checks++; if (issue_data !== mk(3, 5, 0)) begin errors++; $display("FAIL basic_payload_hold got %h exp %h", issue_data, mk(3, 5, 0)); end
  endtask

  task automatic test_wakeup();
    disp_data = mk(4, 9, 0); disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0; disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
    step();
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL wake_unready_held got %0b exp 0", issued); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL wake_occ got %0d exp 1", occupancy); end
    cdb_valid = 2'b01; cdb_tag = {7'd0, 7'd9};
    step();
    checks++; if (issued !== 1'b1 || issue_data.rob_index !== 5'd4) begin errors++; $display("FAIL wake_issue got %0b/%0d exp 1/4", issued, issue_data.rob_index); end
    // Wakeup of both sources arriving in the dispatch cycle itself.
    disp_data = mk(2, 30, 31); disp_valid = 1'b1; cdb_valid = 2'b11; cdb_tag = {7'd31, 7'd30};
    step();
    disp_valid = 1'b0; cdb_valid = '0;
    checks++; if (issued !== 1'b0 || occupancy !== 4'd1) begin errors++; $display("FAIL wake_disp_bypass_write got %0b/%0d exp 0/1", issued, occupancy); end
    step();
    checks++; if (issued !== 1'b1 || issue_data.rob_index !== 5'd2) begin errors++; $display("FAIL wake_disp_bypass_issue got %0b/%0d exp 1/2", issued, issue_data.rob_index); end
  endtask

  task automatic test_age_wrap();
    int robs [3];
    int order [3];
    robs = '{15, 1, 14};
    order = '{14, 15, 1};
    fu_ready = 1'b0; rob_head = 5'd14; disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp_data = mk(robs[i], 1, 2); disp_valid = 1'b1;
      step();
    end
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL age_occ got %0d exp 3", occupancy); end
    fu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (issued !== 1'b1 || issue_data.rob_index !== ROB_W'(order[i])) begin
        errors++; $display("FAIL age_order_%0d got %0b/%0d exp 1/%0d", i, issued, issue_data.rob_index, order[i]);
      end
    end
    rob_head = '0;
  endtask

  task automatic test_full();
    fu_ready = 1'b1; disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp_data = mk(i, 10 + i, 0); disp_valid = 1'b1;
      step();
    end
    disp_valid = 1'b0;
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got %0d exp 8", occupancy); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready got %0b exp 0", disp_ready); end
    disp_data = mk(8, 50, 0); disp_valid = 1'b1; cdb_valid = 2'b10; cdb_tag = {7'd10, 7'd0};
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_not_before_edge got %0b exp 0", disp_ready); end
    step();
    disp_valid = 1'b0; cdb_valid = '0;
    checks++; if (issued !== 1'b1 || issue_data.rob_index !== 5'd0) begin errors++; $display("FAIL full_issue got %0b/%0d exp 1/0", issued, issue_data.rob_index); end
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_occ_after got %0d exp 7", occupancy); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %0b exp 1", disp_ready); end
    mispredict = 1'b1; mispredict_tag = 5'd0; curr_rob_tag = 5'd8;
    step();
    mispredict = 1'b0;
    checks++; if (occupancy !== 4'd0 || issued !== 1'b0) begin errors++; $display("FAIL full_flush got %0d/%0b exp 0/0", occupancy, issued); end
  endtask

  task automatic test_mispredict();
    int robs [4];
    robs = '{4, 5, 6, 8};
    fu_ready = 1'b0; disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp_data = mk(robs[i], 3, 4); disp_valid = 1'b1;
      step();
    end
    checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL mp_occ_before got %0d exp 4", occupancy); end
    mispredict = 1'b1; mispredict_tag = 5'd5; curr_rob_tag = 5'd9; fu_ready = 1'b1;
    disp_data = mk(9, 3, 4);
    #1;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL mp_disp_blocked got %0b exp 0", disp_ready); end
    step();
    mispredict = 1'b0; disp_valid = 1'b0;
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL mp_no_issue got %0b exp 0", issued); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL mp_occ_after got %0d exp 2", occupancy); end
    step();
    checks++; if (issued !== 1'b1 || issue_data.rob_index !== 5'd4) begin errors++; $display("FAIL mp_keep_4 got %0b/%0d exp 1/4", issued, issue_data.rob_index); end
    step();
    checks++; if (issued !== 1'b1 || issue_data.rob_index !== 5'd5) begin errors++; $display("FAIL mp_keep_5 got %0b/%0d exp 1/5", issued, issue_data.rob_index); end
    step();
    checks++; if (issued !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL mp_drained got %0b/%0d exp 0/0", issued, occupancy); end
  endtask

  task automatic test_back_to_back();
    int order [3];
    order = '{6, 7, 10};
    fu_ready = 1'b0; rob_head = '0; disp_ps1_rdy = 1'b1; disp_ps2_rdy = 1'b1;
    disp_data = mk(7, 1, 1); disp_valid = 1'b1;
    step();
    disp_data = mk(6, 1, 1);
    step();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (issued !== 1'b0) begin errors++; $display("FAIL stall_cycle_%0d got %0b exp 0", i, issued); end
    end
    // Release the ALU while dispatching a third ready op in the same cycle.
    fu_ready = 1'b1; disp_data = mk(10, 1, 1); disp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      disp_valid = 1'b0;
      checks++;
      if (issued !== 1'b1 || issue_data.rob_index !== ROB_W'(order[i])) begin
        errors++; $display("FAIL b2b_order_%0d got %0b/%0d exp 1/%0d", i, issued, issue_data.rob_index, order[i]);
      end
      if (i == 0) begin
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL b2b_occ_disp_issue got %0d exp 2", occupancy); end
      end
    end
    step();
    checks++; if (issued !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL b2b_drained got %0b/%0d exp 0/0", issued, occupancy); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_wakeup();
    test_age_wrap();
    test_full();
    test_mispredict();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
